spi_master_cfg: RTL

Configurable SPI master that generalises the team's fixed-mode divide-by-two SPI master. It supports all four CPOL/CPHA modes, a programmable SCK divider, NUM_CS active-low chip selects and MSB- or LSB-first shifting. Configuration is latched per transfer, so one instance can time-share peripherals with different modes and speeds. It sits between the design's control logic (word interface) and the TT IO pins (serial interface).

---
 rtl/spi_master_cfg.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/spi_master_cfg.sv
// Configurable SPI master: all four CPOL/CPHA modes, programmable SCK divider,
// NUM_CS active-low selects and MSB/LSB-first shifting, config latched per transfer.
module spi_master_cfg #(
  parameter int WORD_SIZE = 16,
  parameter int NUM_CS = 2,
  parameter int DIV_BITS = 8,
  localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  output logic                 o_sck,
  output logic [NUM_CS-1:0]    o_sce,
  output logic                 o_sout,
  input  logic                 i_sin,
  input  logic                 i_ena,
  input  logic [CS_W-1:0]      i_cs,
  input  logic                 i_cpol,
  input  logic                 i_cpha,
  input  logic                 i_lsb_first,
  input  logic [DIV_BITS-1:0]  i_div,
  input  logic [WORD_SIZE-1:0] i_win,
  output logic [WORD_SIZE-1:0] o_wout,
  output logic                 o_wstb,
  output logic                 o_busy,
  output logic [1:0]           o_state
);

  // Handshake: i_ena is a level request sampled only in IDLE; o_wstb marks
  // o_wout valid for exactly one cycle, the first cycle with o_busy low.

  localparam int EC_W = $clog2(2 * WORD_SIZE);
  localparam logic [EC_W-1:0] LAST_EDGE = EC_W'(2 * WORD_SIZE - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD} state_t;

  state_t               state, state_n;
  logic [DIV_BITS-1:0]  cnt;
  logic                 tick;

  logic [WORD_SIZE-1:0] tx_sr, tx_d, rx_sr, rx_d, tx_adv;
  logic [EC_W-1:0]      edge_cnt, edge_d;
  logic [CS_W-1:0]      cs_l, cs_d;
  logic                 cpol_l, cpol_d, cpha_l, cpha_d, lsb_l, lsb_d;
  logic [DIV_BITS-1:0]  div_l, div_d;
  logic                 lead, last;

  logic                 sck_d, sout_d, busy_d, wstb_d;
  logic [NUM_CS-1:0]    sce_d;
  logic [WORD_SIZE-1:0] wout_d;

  function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] idx);
    logic [NUM_CS-1:0] m;
    m = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (idx == CS_W'(i)) m[i] = 1'b0;
    end
    return m;
  endfunction

  assign tick    = (cnt == div_l);
  assign lead    = ~edge_cnt[0];
  assign last    = (edge_cnt == LAST_EDGE);
  assign tx_adv  = lsb_l ? (tx_sr >> 1) : (tx_sr << 1);
  assign o_state = state;

  // State register; the divider restarts on every state entry.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (state_n != state || tick || state == S_IDLE) cnt <= '0;
      else cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (i_ena) state_n = S_SETUP;
      S_SETUP: if (tick) state_n = S_SHIFT;
      S_SHIFT: if (tick && last) state_n = S_HOLD;
      S_HOLD:  if (tick) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Next values of all registered outputs and the shift datapath.
  always_comb begin
    sck_d  = o_sck;
    sce_d  = o_sce;
    sout_d = o_sout;
    busy_d = o_busy;
    wstb_d = 1'b0;
    wout_d = o_wout;
    tx_d   = tx_sr;
    rx_d   = rx_sr;
    edge_d = edge_cnt;
    cs_d   = cs_l;
    cpol_d = cpol_l;
    cpha_d = cpha_l;
    lsb_d  = lsb_l;
    div_d  = div_l;
    case (state)
      S_IDLE: begin
        sck_d  = i_cpol;
        sce_d  = '1;
        sout_d = 1'b0;
        busy_d = 1'b0;
        if (i_ena) begin
          tx_d   = i_win;
          rx_d   = '0;
          edge_d = '0;
          cs_d   = i_cs;
          cpol_d = i_cpol;
          cpha_d = i_cpha;
          lsb_d  = i_lsb_first;
          div_d  = i_div;
          sce_d  = cs_decode(i_cs);
          sout_d = i_lsb_first ? i_win[0] : i_win[WORD_SIZE-1];
          busy_d = 1'b1;
        end
      end
      S_SHIFT: begin
        if (tick) begin
          sck_d  = ~o_sck;
          edge_d = edge_cnt + 1'b1;
          if (lead ^ cpha_l) begin
            rx_d = lsb_l ? {i_sin, rx_sr[WORD_SIZE-1:1]} : {rx_sr[WORD_SIZE-2:0], i_sin};
          end
          // CPHA=1 re-drives the first bit on edge 0, so it advances only from edge 2 on.
          if (cpha_l ? (lead && edge_cnt != '0) : (!lead && !last)) begin
            tx_d   = tx_adv;
            sout_d = lsb_l ? tx_adv[0] : tx_adv[WORD_SIZE-1];
          end
        end
      end
      S_HOLD: begin
        if (tick) begin
          sck_d  = cpol_l;
          sce_d  = '1;
          sout_d = 1'b0;
          busy_d = 1'b0;
          wstb_d = 1'b1;
          wout_d = rx_sr;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_sck    <= 1'b0;
      o_sce    <= '1;
      o_sout   <= 1'b0;
      o_busy   <= 1'b0;
      o_wstb   <= 1'b0;
      o_wout   <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      edge_cnt <= '0;
      cs_l     <= '0;
      cpol_l   <= 1'b0;
      cpha_l   <= 1'b0;
      lsb_l    <= 1'b0;
      div_l    <= '0;
    end else begin
      o_sck    <= sck_d;
      o_sce    <= sce_d;
      o_sout   <= sout_d;
      o_busy   <= busy_d;
      o_wstb   <= wstb_d;
      o_wout   <= wout_d;
      tx_sr    <= tx_d;
      rx_sr    <= rx_d;
      edge_cnt <= edge_d;
      cs_l     <= cs_d;
      cpol_l   <= cpol_d;
      cpha_l   <= cpha_d;
      lsb_l    <= lsb_d;
      div_l    <= div_d;
    end
  end

endmodule
